// File: rtl/ultrasonic_ranger.sv
// Multi-channel HC-SR04-style ranging controller: round-robin trigger, echo timing, result strobe.
// Define ULTRA_AVG_EN to report a two-sample running average per channel instead of raw widths.
module ultrasonic_ranger #(
    parameter int NUM_CH         = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int GAP_CYCLES     = 3_000_000,
    parameter int CNT_W          = 22,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trig,
    output logic              busy,
    output logic              dist_valid,
    output logic [CH_W-1:0]   dist_ch,
    output logic [CNT_W-1:0]  dist_cycles,
    output logic              timeout,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]    r_ch, w_ch_nxt;
    logic [NUM_CH-1:0]  r_echo_s1, r_echo_s2, r_echo_d;
    logic               r_dist_valid, r_timeout;
    logic [CH_W-1:0]    r_dist_ch;
    logic [CNT_W-1:0]   r_dist_cycles;
    logic               w_echo_now, w_echo_prev, w_rise;
    logic               w_report, w_report_to;
    logic [CNT_W-1:0]   w_raw, w_result;

    // Two-flop synchroniser plus one delayed copy for edge detection on the synced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
            r_echo_d  <= '0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    assign w_echo_now  = r_echo_s2[r_ch];
    assign w_echo_prev = r_echo_d[r_ch];
    assign w_rise      = w_echo_now & ~w_echo_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_report    = 1'b0;
        w_report_to = 1'b0;
        w_raw       = '0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_TRIG;
                    w_cnt_nxt   = '0;
                end
            end
            S_TRIG: begin
                if (r_cnt >= TRIG_LAST) begin
                    w_state_nxt = S_WAIT_RISE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt >= TO_LAST) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = '0;
                    w_report    = 1'b1;
                    w_report_to = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_MEASURE: begin
                if (!w_echo_now) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = '0;
                    w_report    = 1'b1;
                    w_raw       = r_cnt;
                end else if (r_cnt >= TO_LAST) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = '0;
                    w_report    = 1'b1;
                    w_report_to = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (r_cnt >= GAP_LAST) begin
                    w_ch_nxt    = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                    w_state_nxt = enable ? S_TRIG : S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ULTRA_AVG_EN
    logic [CNT_W-1:0]  r_prev [NUM_CH];
    logic [NUM_CH-1:0] r_prev_ok;
    logic [CNT_W:0]    w_sum;

    assign w_sum    = {1'b0, r_prev[r_ch]} + {1'b0, w_raw};
    assign w_result = r_prev_ok[r_ch] ? w_sum[CNT_W:1] : w_raw;

    // A timeout breaks the history so the next good reading is reported raw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_prev[i] <= '0;
            r_prev_ok <= '0;
        end else if (w_report) begin
            if (w_report_to) begin
                r_prev_ok[r_ch] <= 1'b0;
            end else begin
                r_prev[r_ch]    <= w_raw;
                r_prev_ok[r_ch] <= 1'b1;
            end
        end
    end
`else
    assign w_result = w_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ch          <= '0;
            r_dist_valid  <= 1'b0;
            r_dist_ch     <= '0;
            r_dist_cycles <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ch         <= w_ch_nxt;
            r_dist_valid <= w_report;
            if (w_report) begin
                r_dist_ch     <= r_ch;
                r_dist_cycles <= w_report_to ? '0 : w_result;
                r_timeout     <= w_report_to;
            end
        end
    end

    // Decoded straight from the state register so an asynchronous reset drops trig at once.
    assign trig        = (r_state == S_TRIG) ? (NUM_CH'(1) << r_ch) : '0;
    assign busy        = (r_state != S_IDLE);
    assign dist_valid  = r_dist_valid;
    assign dist_ch     = r_dist_ch;
    assign dist_cycles = r_dist_cycles;
    assign timeout     = r_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: table of echo scenarios over a continuous scan, scoreboarded results,
// plus hand-written enable-drop, reset-in-MEASURE and reset-in-TRIG sequences.
module tb_ultrasonic_ranger;

    localparam int NUM_CH = 4;
    localparam int TRIG   = 5;
    localparam int TMO    = 100;
    localparam int GAP    = 20;
    localparam int CNT_W  = 22;
    localparam int QW     = 1 + 2 + 1 + CNT_W;
    localparam int NVEC   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [3:0]        echo;
    logic [3:0]        trig;
    logic              busy;
    logic              dist_valid;
    logic [1:0]        dist_ch;
    logic [CNT_W-1:0]  dist_cycles;
    logic              timeout;
    logic [2:0]        dbg_state;

    ultrasonic_ranger #(
        .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES(GAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig), .busy(busy),
        .dist_valid(dist_valid), .dist_ch(dist_ch), .dist_cycles(dist_cycles),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       ch;
        int               dly;
        int               wid;
        bit               pre;
        bit               exp_to;
        logic [CNT_W-1:0] exp_raw;
    } vec_t;

    vec_t             vecs [NVEC];
    logic [QW-1:0]    exp_q [$];
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               gap_chk  = 1'b0;
    int               n_trig, n_valid, exp_ch, hi_cnt, since_fall, since_valid;
    bit               have_valid;
    logic [3:0]       prev_trig;
`ifdef ULTRA_AVG_EN
    logic [CNT_W-1:0] m_prev    [NUM_CH];
    bit               m_prev_ok [NUM_CH];
`endif

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void set_vec(input int i, input logic [1:0] ch, input int dly, input int wid,
                                    input bit pre, input bit to, input int raw);
        vecs[i].ch      = ch;
        vecs[i].dly     = dly;
        vecs[i].wid     = wid;
        vecs[i].pre     = pre;
        vecs[i].exp_to  = to;
        vecs[i].exp_raw = CNT_W'(raw);
    endfunction

    function automatic void model_reset();
`ifdef ULTRA_AVG_EN
        for (int i = 0; i < NUM_CH; i++) begin
            m_prev[i]    = '0;
            m_prev_ok[i] = 1'b0;
        end
`endif
    endfunction

    task automatic spawn_pulse(input logic [1:0] c, input int d, input int w);
        fork
            begin
                repeat (d) @(negedge clk);
                echo[c] = 1'b1;
                repeat (w) @(negedge clk);
                echo[c] = 1'b0;
            end
        join_none
    endtask

    // Waits for the next trigger, queues the expected result, then schedules the echo pulse.
    task automatic run_vec(input vec_t v, input bit last);
        int               c;
        logic [CNT_W-1:0] val;
        bit               lat;
        c = 0;
        while (trig == 4'd0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("trig_fires", (trig != 4'd0), 1);
        if (trig == 4'd0) return;
        check("vec_trig_ch", trig, 4'(1) << v.ch);
        val = v.exp_raw;
`ifdef ULTRA_AVG_EN
        if (v.exp_to) begin
            m_prev_ok[v.ch] = 1'b0;
        end else begin
            if (m_prev_ok[v.ch]) val = CNT_W'(({1'b0, m_prev[v.ch]} + {1'b0, v.exp_raw}) >> 1);
            m_prev[v.ch]    = v.exp_raw;
            m_prev_ok[v.ch] = 1'b1;
        end
`endif
        lat = (v.wid == 0) && !v.pre;
        exp_q.push_back({lat, v.ch, v.exp_to, val});
        if (v.pre) spawn_pulse(v.ch, 0, v.wid);
        c = 0;
        while (trig != 4'd0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (last) enable = 1'b0;
        if (!v.pre && v.wid > 0) spawn_pulse(v.ch, v.dly, v.wid);
    endtask

    task automatic wait_idle(input int lim);
        int c;
        c = 0;
        while (busy && c < lim) begin
            @(negedge clk);
            c++;
        end
        check("return_to_idle", busy, 0);
    endtask

    // Monitor: trigger order/width/holdoff and scoreboard comparison of every result strobe.
    initial begin
        logic [QW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_trig = '0; hi_cnt = 0; exp_ch = 0; have_valid = 1'b0;
                n_trig = 0; n_valid = 0; since_fall = 0; since_valid = 0;
            end else begin
                since_fall++;
                since_valid++;
                if (trig != 4'd0) begin
                    hi_cnt++;
                    if (prev_trig == 4'd0) begin
                        check("trig_onehot", $onehot(trig), 1);
                        check("trig_order", trig, 4'(1) << exp_ch);
                        exp_ch = (exp_ch + 1) % NUM_CH;
                        if (gap_chk && have_valid) check("holdoff_gap", since_valid, GAP);
                    end else begin
                        check("trig_stable", trig, prev_trig);
                    end
                end else if (prev_trig != 4'd0) begin
                    check("trig_width", hi_cnt, TRIG);
                    hi_cnt = 0;
                    since_fall = 0;
                    n_trig++;
                end
                if (dist_valid) begin
                    n_valid++;
                    have_valid = 1'b1;
                    since_valid = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got dist_valid=1 ch=%0d, required no result", dist_ch);
                    end else begin
                        e = exp_q.pop_front();
                        check("dist_ch", dist_ch, e[QW-2 -: 2]);
                        check("timeout", timeout, e[CNT_W]);
                        check("dist_cycles", dist_cycles, e[CNT_W-1:0]);
                        if (e[QW-1]) check("no_echo_latency", since_fall, TMO);
                    end
                end
                prev_trig = trig;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   c;
        rst = 1'b1; enable = 1'b0; echo = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_dist_valid", dist_valid, 0);
        check("rst_dist_ch", dist_ch, 0);
        check("rst_dist_cycles", dist_cycles, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_without_enable", busy, 0);

        //          idx ch dly wid pre to raw
        set_vec( 0, 0, 10,  40, 0, 0, 40);
        set_vec( 1, 1,  0,   0, 0, 1,  0);
        set_vec( 2, 2, 10, 150, 0, 1,  0);
        set_vec( 3, 3,  5,   1, 0, 0,  1);
        set_vec( 4, 0,  3,  60, 0, 0, 60);
        set_vec( 5, 1, 20, 100, 0, 1,  0);
        set_vec( 6, 2, 90,  10, 0, 0, 10);
        set_vec( 7, 3,  1,  33, 0, 0, 33);
        set_vec( 8, 0,  8,   0, 0, 1,  0);
        set_vec( 9, 1,  4,   7, 0, 0,  7);
        set_vec(10, 2,  6,   2, 0, 0,  2);
        set_vec(11, 3,  2,  50, 0, 0, 50);
        set_vec(12, 0,  5,  20, 0, 0, 20);
        set_vec(13, 1,  2,   9, 0, 0,  9);
        set_vec(14, 2,  0,  30, 1, 1,  0);

        enable = 1'b1;
        gap_chk = 1'b1;
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i == NVEC - 1);
        wait_idle(400);
        gap_chk = 1'b0;
        check("scan_queue_drained", exp_q.size(), 0);
        check("scan_trig_count", n_trig, NVEC);
        check("one_valid_per_trig", n_valid, n_trig);
        repeat (10) @(negedge clk);
        check("stays_idle", busy, 0);

        // Scan resumes at the channel after the one that finished before enable dropped.
        enable = 1'b1;
        v.ch = 2'd3; v.dly = 5; v.wid = 60; v.pre = 1'b0; v.exp_to = 1'b0; v.exp_raw = CNT_W'(60);
        run_vec(v, 1'b0);
        c = 0;
        while (dbg_state != 3'd3 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("reach_measure", dbg_state, 3);
        #2 rst = 1'b1;
        #1;
        check("rst_measure_trig", trig, 0);
        check("rst_measure_busy", busy, 0);
        check("rst_measure_state", dbg_state, 0);
        exp_q.delete();
        model_reset();
        repeat (100) @(negedge clk);
        rst = 1'b0;
        echo = '0;

        c = 0;
        while (trig == 4'd0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("ch0_after_reset", trig, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("trig_async_drop", trig, 0);
        check("rst_trig_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        v.ch = 2'd0; v.dly = 10; v.wid = 25; v.pre = 1'b0; v.exp_to = 1'b0; v.exp_raw = CNT_W'(25);
        run_vec(v, 1'b1);
        wait_idle(300);
        check("final_queue_drained", exp_q.size(), 0);
        check("final_valid_count", n_valid, 1);
        check("final_trig_count", n_trig, 1);
        check("hold_dist_valid", dist_valid, 0);
        check("hold_dist_ch", dist_ch, 0);
        check("hold_dist_cycles", dist_cycles, 25);
        check("hold_timeout", timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
